// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    localparam logic [3:0] BYTE_EN_ALL = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one fixed-latency memory between fetch
// and the data memory stage; data always wins over fetch.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_ack_o,
    input  logic                  dm_req_i,
    input  logic                  dm_wr_en_i,
    input  logic [3:0]            dm_byte_en_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wr_data_i,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  dm_ack_o,
    output logic                  mem_en_o,
    output logic                  mem_wr_en_o,
    output logic [3:0]            mem_byte_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wr_data_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  stall_f_o,
    output logic                  stall_m_o
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    arb_state_t       state;
    arb_owner_t       owner;
    logic [CNT_W-1:0] cnt;
    logic             wr_q;
    logic             dm_elig;
    logic             if_elig;

    // A requester still holds req during its own ack cycle, so mask it there.
    assign dm_elig   = dm_req_i & ~dm_ack_o;
    assign if_elig   = if_req_i & ~if_ack_o;
    assign stall_f_o = if_req_i & ~if_ack_o;
    assign stall_m_o = dm_req_i & ~dm_ack_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB_IDLE;
            owner         <= OWN_IF;
            cnt           <= '0;
            wr_q          <= 1'b0;
            if_ack_o      <= 1'b0;
            dm_ack_o      <= 1'b0;
            if_rdata_o    <= '0;
            dm_rdata_o    <= '0;
            mem_en_o      <= 1'b0;
            mem_wr_en_o   <= 1'b0;
            mem_byte_en_o <= '0;
            mem_addr_o    <= '0;
            mem_wr_data_o <= '0;
        end else begin
            if_ack_o    <= 1'b0;
            dm_ack_o    <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_wr_en_o <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (dm_elig) begin
                        state         <= ARB_BUSY;
                        owner         <= OWN_DM;
                        cnt           <= CNT_W'(MEM_LATENCY);
                        wr_q          <= dm_wr_en_i;
                        mem_en_o      <= 1'b1;
                        mem_wr_en_o   <= dm_wr_en_i;
                        mem_byte_en_o <= dm_byte_en_i;
                        mem_addr_o    <= dm_addr_i;
                        mem_wr_data_o <= dm_wr_data_i;
                    end else if (if_elig) begin
                        state         <= ARB_BUSY;
                        owner         <= OWN_IF;
                        cnt           <= CNT_W'(MEM_LATENCY);
                        wr_q          <= 1'b0;
                        mem_en_o      <= 1'b1;
                        mem_byte_en_o <= BYTE_EN_ALL;
                        mem_addr_o    <= if_addr_i;
                        mem_wr_data_o <= '0;
                    end
                end
                ARB_BUSY: begin
                    // Counter reaches zero in the cycle the memory data is valid.
                    if (cnt == '0) begin
                        state <= ARB_IDLE;
                        if (owner == OWN_DM) begin
                            dm_ack_o <= 1'b1;
                            if (!wr_q) begin
                                dm_rdata_o <= mem_rdata_i;
                            end
                        end else begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= mem_rdata_i;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 2 and 1), a timeline
// model checked every cycle, and directed literal checks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;

    logic        if_req[2];
    logic [31:0] if_addr[2];
    logic [31:0] if_rdata[2];
    logic        if_ack[2];
    logic        dm_req[2];
    logic        dm_wr[2];
    logic [3:0]  dm_be[2];
    logic [31:0] dm_addr[2];
    logic [31:0] dm_wd[2];
    logic [31:0] dm_rdata[2];
    logic        dm_ack[2];
    logic        mem_en[2];
    logic        mem_wr[2];
    logic [3:0]  mem_be[2];
    logic [31:0] mem_addr[2];
    logic [31:0] mem_wd[2];
    logic [31:0] mem_rdata[2];
    logic        stall_f[2];
    logic        stall_m[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst),
        .if_req_i(if_req[0]), .if_addr_i(if_addr[0]),
        .if_rdata_o(if_rdata[0]), .if_ack_o(if_ack[0]),
        .dm_req_i(dm_req[0]), .dm_wr_en_i(dm_wr[0]),
        .dm_byte_en_i(dm_be[0]), .dm_addr_i(dm_addr[0]),
        .dm_wr_data_i(dm_wd[0]), .dm_rdata_o(dm_rdata[0]),
        .dm_ack_o(dm_ack[0]), .mem_en_o(mem_en[0]),
        .mem_wr_en_o(mem_wr[0]), .mem_byte_en_o(mem_be[0]),
        .mem_addr_o(mem_addr[0]), .mem_wr_data_o(mem_wd[0]),
        .mem_rdata_i(mem_rdata[0]),
        .stall_f_o(stall_f[0]), .stall_m_o(stall_m[0])
    );

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req_i(if_req[1]), .if_addr_i(if_addr[1]),
        .if_rdata_o(if_rdata[1]), .if_ack_o(if_ack[1]),
        .dm_req_i(dm_req[1]), .dm_wr_en_i(dm_wr[1]),
        .dm_byte_en_i(dm_be[1]), .dm_addr_i(dm_addr[1]),
        .dm_wr_data_i(dm_wd[1]), .dm_rdata_o(dm_rdata[1]),
        .dm_ack_o(dm_ack[1]), .mem_en_o(mem_en[1]),
        .mem_wr_en_o(mem_wr[1]), .mem_byte_en_o(mem_be[1]),
        .mem_addr_o(mem_addr[1]), .mem_wr_data_o(mem_wd[1]),
        .mem_rdata_i(mem_rdata[1]),
        .stall_f_o(stall_f[1]), .stall_m_o(stall_m[1])
    );

    function automatic int lat(int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (a == 32'h4) return 32'h0050_0093;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d] cyc %0d: got %h want %h", name, k, cyc, act, exp);
    endtask

    // Memory responder: returns mem_word(addr) exactly LAT cycles after mem_en.
    int          due[2] = '{-1, -1};
    logic [31:0] raddr[2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_en[k] === 1'b1) begin
                due[k]   = cyc + lat(k);
                raddr[k] = mem_addr[k];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            mem_rdata[k] = (cyc == due[k]) ? mem_word(raddr[k])
                                           : (32'hBAD0_0000 | cyc);
        end
    end

    // Timeline model: an access granted in cycle g issues at g+1,
    // is busy until g+L+1 and acks at g+L+2.
    int          gnt[2] = '{-1, -1};
    bit          own_dm[2];
    bit          m_wr[2];
    logic [3:0]  m_be[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wd[2];
    logic [31:0] e_if_rd[2];
    logic [31:0] e_dm_rd[2];
    bit          rst_q = 1'b0;
    bit          armed = 1'b0;

    always @(negedge clk) begin
        if (rst_q) armed = 1'b1;
        for (int k = 0; k < 2; k++) begin
            int l;
            bit live, busy, e_en, a_if, a_dm;
            l = lat(k);
            if (rst_q) begin
                gnt[k]     = -1;
                e_if_rd[k] = '0;
                e_dm_rd[k] = '0;
            end
            live = gnt[k] >= 0;
            busy = live && cyc > gnt[k] && cyc <= gnt[k] + l + 1;
            e_en = live && cyc == gnt[k] + 1;
            a_if = live && cyc == gnt[k] + l + 2 && !own_dm[k];
            a_dm = live && cyc == gnt[k] + l + 2 && own_dm[k];
            if (a_if) e_if_rd[k] = mem_word(m_addr[k]);
            if (a_dm && !m_wr[k]) e_dm_rd[k] = mem_word(m_addr[k]);
            if (armed) begin
                chk("mem_en", k, 32'(mem_en[k]), 32'(e_en));
                chk("mem_wr", k, 32'(mem_wr[k]), 32'(e_en && m_wr[k]));
                chk("if_ack", k, 32'(if_ack[k]), 32'(a_if));
                chk("dm_ack", k, 32'(dm_ack[k]), 32'(a_dm));
                chk("if_rdata", k, if_rdata[k], e_if_rd[k]);
                chk("dm_rdata", k, dm_rdata[k], e_dm_rd[k]);
                chk("stall_f", k, 32'(stall_f[k]), 32'(if_req[k] && !a_if));
                chk("stall_m", k, 32'(stall_m[k]), 32'(dm_req[k] && !a_dm));
                if (busy) begin
                    chk("mem_addr", k, mem_addr[k], m_addr[k]);
                    chk("mem_be", k, 32'(mem_be[k]), 32'(m_be[k]));
                    if (m_wr[k]) chk("mem_wd", k, mem_wd[k], m_wd[k]);
                end
                if (rst_q) begin
                    chk("rst_addr", k, mem_addr[k], 32'h0);
                    chk("rst_be", k, 32'(mem_be[k]), 32'h0);
                    chk("rst_wd", k, mem_wd[k], 32'h0);
                end
            end
            if (!busy && !rst) begin
                if (dm_req[k] && !a_dm) begin
                    gnt[k]    = cyc;
                    own_dm[k] = 1'b1;
                    m_wr[k]   = dm_wr[k];
                    m_be[k]   = dm_be[k];
                    m_addr[k] = dm_addr[k];
                    m_wd[k]   = dm_wd[k];
                end else if (if_req[k] && !a_if) begin
                    gnt[k]    = cyc;
                    own_dm[k] = 1'b0;
                    m_wr[k]   = 1'b0;
                    m_be[k]   = 4'b1111;
                    m_addr[k] = if_addr[k];
                end
            end
        end
        rst_q = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            if_req[k]  = 1'b0;
            if_addr[k] = '0;
            dm_req[k]  = 1'b0;
            dm_wr[k]   = 1'b0;
            dm_be[k]   = 4'b0;
            dm_addr[k] = '0;
            dm_wd[k]   = '0;
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single fetch, latency 2.
        for (int i = 0; i < 6; i++) begin
            if_req[0]  = (i <= 4);
            if_addr[0] = 32'h4;
            probe();
            if (i == 1) begin
                chk("t1_en", 0, 32'(mem_en[0]), 32'h1);
                chk("t1_addr", 0, mem_addr[0], 32'h4);
                chk("t1_wr", 0, 32'(mem_wr[0]), 32'h0);
            end
            if (i == 3) chk("t1_stall3", 0, 32'(stall_f[0]), 32'h1);
            if (i == 4) begin
                chk("t1_ack", 0, 32'(if_ack[0]), 32'h1);
                chk("t1_rdata", 0, if_rdata[0], 32'h0050_0093);
                chk("t1_stall4", 0, 32'(stall_f[0]), 32'h0);
            end
            tick();
        end

        // Simultaneous load and fetch: data first.
        for (int i = 0; i < 10; i++) begin
            dm_req[0]  = (i <= 4);
            dm_addr[0] = 32'h100;
            if_req[0]  = (i <= 8);
            if_addr[0] = 32'h8;
            probe();
            if (i == 1) chk("t2_addr1", 0, mem_addr[0], 32'h100);
            if (i == 4) begin
                chk("t2_dmack", 0, 32'(dm_ack[0]), 32'h1);
                chk("t2_dmrd", 0, dm_rdata[0], 32'h5A5A_0100);
            end
            if (i == 5) begin
                chk("t2_en5", 0, 32'(mem_en[0]), 32'h1);
                chk("t2_addr5", 0, mem_addr[0], 32'h8);
            end
            if (i == 8) begin
                chk("t2_ifack", 0, 32'(if_ack[0]), 32'h1);
                chk("t2_ifrd", 0, if_rdata[0], 32'h5A5A_0008);
            end
            tick();
        end

        // Byte-lane store.
        for (int i = 0; i < 6; i++) begin
            dm_req[0]  = (i <= 4);
            dm_wr[0]   = 1'b1;
            dm_be[0]   = 4'b0011;
            dm_addr[0] = 32'h200;
            dm_wd[0]   = 32'hDEAD_BEEF;
            probe();
            if (i == 1) begin
                chk("t3_wr", 0, 32'(mem_wr[0]), 32'h1);
                chk("t3_be", 0, 32'(mem_be[0]), 32'h3);
                chk("t3_wd", 0, mem_wd[0], 32'hDEAD_BEEF);
            end else begin
                chk("t3_wr0", 0, 32'(mem_wr[0]), 32'h0);
            end
            if (i == 4) begin
                chk("t3_ack", 0, 32'(dm_ack[0]), 32'h1);
                chk("t3_hold", 0, dm_rdata[0], 32'h5A5A_0100);
            end
            tick();
        end
        dm_wr[0] = 1'b0;
        dm_be[0] = 4'b0;

        // Fetch request held across two accesses.
        for (int i = 0; i < 11; i++) begin
            if_req[0]  = (i <= 9);
            if_addr[0] = 32'hC;
            probe();
            if (i == 4) chk("t4_ack4", 0, 32'(if_ack[0]), 32'h1);
            if (i == 5) chk("t4_en5", 0, 32'(mem_en[0]), 32'h0);
            if (i == 6) chk("t4_en6", 0, 32'(mem_en[0]), 32'h1);
            if (i == 9) chk("t4_ack9", 0, 32'(if_ack[0]), 32'h1);
            tick();
        end

        // Reset during an in-flight fetch.
        for (int i = 0; i < 11; i++) begin
            if_req[0]  = (i <= 2) || (i >= 5 && i <= 9);
            if_addr[0] = (i <= 2) ? 32'h10 : 32'h14;
            rst        = (i == 2);
            probe();
            if (i == 3) begin
                chk("t5_en", 0, 32'(mem_en[0]), 32'h0);
                chk("t5_addr", 0, mem_addr[0], 32'h0);
                chk("t5_ifrd", 0, if_rdata[0], 32'h0);
                chk("t5_dmrd", 0, dm_rdata[0], 32'h0);
            end
            if (i == 4) chk("t5_noack", 0, 32'(if_ack[0]), 32'h0);
            if (i == 9) begin
                chk("t5_ack", 0, 32'(if_ack[0]), 32'h1);
                chk("t5_rd", 0, if_rdata[0], 32'h5A5A_0014);
            end
            tick();
        end
        rst = 1'b0;

        // Latency 1: load, then a waiting fetch granted in the ack cycle.
        for (int i = 0; i < 8; i++) begin
            dm_req[1]  = (i <= 3);
            dm_addr[1] = 32'h300;
            if_req[1]  = (i <= 6);
            if_addr[1] = 32'h18;
            probe();
            if (i == 1) chk("t6_addr1", 1, mem_addr[1], 32'h300);
            if (i == 3) begin
                chk("t6_ack", 1, 32'(dm_ack[1]), 32'h1);
                chk("t6_rd", 1, dm_rdata[1], 32'h5A5A_0300);
            end
            if (i == 4) begin
                chk("t6_en4", 1, 32'(mem_en[1]), 32'h1);
                chk("t6_addr4", 1, mem_addr[1], 32'h18);
            end
            if (i == 6) chk("t6_ifack", 1, 32'(if_ack[1]), 32'h1);
            tick();
        end

        tick();
        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
